// File: rtl/lifo_arbiter_pkg.sv
// Shared encodings for the two-requester LIFO arbiter.
package lifo_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_REJECT  = 2'd3
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/lifo_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter2
  import lifo_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_c,
  output logic valid_c
);

  // Combinational grant selection
  always_comb begin
    grant_c = GRANT_A;
    valid_c = req_a | req_b;
    if (req_a && req_b) begin
      grant_c = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
    end else if (req_b) begin
      grant_c = GRANT_B;
    end
  end

endmodule

// File: rtl/lifo_arbiter.sv
// Arbitrates two requesters onto one LIFO stack, guarding against overflow/underflow.
module lifo_arbiter
  import lifo_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STACK_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  op_a,
  input  logic                  op_b,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  ack_a,
  output logic                  ack_b,
  output logic                  err_a,
  output logic                  err_b,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  mismatch,
  output logic                  stk_reset,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_wdata,
  input  logic [DATA_WIDTH-1:0] stk_rdata,
  input  logic                  stk_error
);

  localparam int unsigned CNT_W = $clog2(STACK_SIZE + 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    last_grant_q, last_grant_d;
  logic                    grant_q, grant_d;
  logic                    op_q, op_d;
  logic                    flush_lat_q, flush_lat_d;
  logic                    err_snap_q, err_snap_d;

  logic                    ack_a_d, ack_b_d, err_a_d, err_b_d;
  logic [DATA_WIDTH-1:0]   rdata_d, stk_wdata_d;
  logic                    full_d, empty_d, mismatch_d;
  logic                    stk_reset_d, stk_push_d, stk_pop_d;

  logic                    arb_grant_c, arb_valid_c;
  logic                    sel_op_c;
  logic [DATA_WIDTH-1:0]   sel_wdata_c;
  logic                    flush_pend_c, cnt_full_c, cnt_empty_c;

  rr_arbiter2 u_rr (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant_q),
    .grant_c    (arb_grant_c),
    .valid_c    (arb_valid_c)
  );

  // Operand of the requester the arbiter would pick, plus count-based guards
  always_comb begin
    sel_op_c     = (arb_grant_c == GRANT_A) ? op_a : op_b;
    sel_wdata_c  = (arb_grant_c == GRANT_A) ? wdata_a : wdata_b;
    flush_pend_c = flush | flush_lat_q;
    cnt_full_c   = (count_q == CNT_W'(STACK_SIZE));
    cnt_empty_c  = (count_q == '0);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_d         = op_q;
    flush_lat_d  = flush_lat_q | flush;
    err_snap_d   = err_snap_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    err_a_d      = 1'b0;
    err_b_d      = 1'b0;
    rdata_d      = rdata;
    mismatch_d   = mismatch;
    stk_reset_d  = 1'b0;
    stk_push_d   = 1'b0;
    stk_pop_d    = 1'b0;
    stk_wdata_d  = stk_wdata;

    case (state_q)
      ST_IDLE: begin
        if (flush_pend_c) begin
          count_d     = '0;
          stk_reset_d = 1'b1;
          flush_lat_d = 1'b0;
        end else if (arb_valid_c) begin
          grant_d = arb_grant_c;
          op_d    = sel_op_c;
          if ((sel_op_c == OP_PUSH && cnt_full_c) || (sel_op_c == OP_POP && cnt_empty_c)) begin
            state_d = ST_REJECT;
            ack_a_d = (arb_grant_c == GRANT_A);
            ack_b_d = (arb_grant_c == GRANT_B);
            err_a_d = (arb_grant_c == GRANT_A);
            err_b_d = (arb_grant_c == GRANT_B);
          end else begin
            state_d     = ST_ISSUE;
            stk_push_d  = (sel_op_c == OP_PUSH);
            stk_pop_d   = (sel_op_c == OP_POP);
            stk_wdata_d = sel_wdata_c;
            err_snap_d  = stk_error;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
        ack_a_d = (grant_q == GRANT_A);
        ack_b_d = (grant_q == GRANT_B);
        if (op_q == OP_PUSH) begin
          count_d = count_q + CNT_W'(1);
        end else begin
          count_d = count_q - CNT_W'(1);
          rdata_d = stk_rdata;
        end
      end
      ST_CAPTURE: begin
        state_d      = ST_IDLE;
        last_grant_d = grant_q;
        if (stk_error && !err_snap_q) begin
          mismatch_d = 1'b1;
        end
      end
      ST_REJECT: begin
        state_d      = ST_IDLE;
        last_grant_d = grant_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    full_d  = (count_d == CNT_W'(STACK_SIZE));
    empty_d = (count_d == '0);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      last_grant_q <= GRANT_B;
      grant_q      <= GRANT_A;
      op_q         <= OP_POP;
      flush_lat_q  <= 1'b0;
      err_snap_q   <= 1'b0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      err_a        <= 1'b0;
      err_b        <= 1'b0;
      rdata        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      mismatch     <= 1'b0;
      stk_reset    <= 1'b1;
      stk_push     <= 1'b0;
      stk_pop      <= 1'b0;
      stk_wdata    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      flush_lat_q  <= flush_lat_d;
      err_snap_q   <= err_snap_d;
      ack_a        <= ack_a_d;
      ack_b        <= ack_b_d;
      err_a        <= err_a_d;
      err_b        <= err_b_d;
      rdata        <= rdata_d;
      full         <= full_d;
      empty        <= empty_d;
      mismatch     <= mismatch_d;
      stk_reset    <= stk_reset_d;
      stk_push     <= stk_push_d;
      stk_pop      <= stk_pop_d;
      stk_wdata    <= stk_wdata_d;
    end
  end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter with a behavioural 4-deep stack attached.
module tb_lifo_arbiter;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       req_a, req_b, op_a, op_b;
  logic [7:0] wdata_a, wdata_b;
  logic       ack_a, ack_b, err_a, err_b;
  logic [7:0] rdata;
  logic       full, empty, mismatch;
  logic       stk_reset, stk_push, stk_pop;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata = 8'h00;
  logic       stk_error;

  logic       model_err = 1'b0;
  logic       force_err;
  logic [7:0] mem [0:3];
  logic [2:0] sp = 3'd0;

  int checks   = 0;
  int failures = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;
  int viol_cnt = 0;

  lifo_arbiter #(.DATA_WIDTH(8), .STACK_SIZE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_a     (req_a),
    .req_b     (req_b),
    .op_a      (op_a),
    .op_b      (op_b),
    .wdata_a   (wdata_a),
    .wdata_b   (wdata_b),
    .ack_a     (ack_a),
    .ack_b     (ack_b),
    .err_a     (err_a),
    .err_b     (err_b),
    .rdata     (rdata),
    .full      (full),
    .empty     (empty),
    .mismatch  (mismatch),
    .stk_reset (stk_reset),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .stk_error (stk_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign stk_error = model_err | force_err;

  // Stack model: commits on the falling edge of the strobe cycle
  always @(negedge clk) begin
    if (stk_reset) begin
      sp        <= 3'd0;
      model_err <= 1'b0;
    end else if (stk_push) begin
      if (sp == 3'd4) model_err <= 1'b1;
      else begin
        mem[sp[1:0]] <= stk_wdata;
        sp           <= sp + 3'd1;
      end
    end else if (stk_pop) begin
      if (sp == 3'd0) model_err <= 1'b1;
      else begin
        stk_rdata <= mem[2'(sp - 3'd1)];
        sp        <= sp - 3'd1;
      end
    end
  end

  // Strobe counters and protocol-rule watcher
  always @(posedge clk) begin
    if (stk_push) push_cnt <= push_cnt + 1;
    if (stk_pop)  pop_cnt  <= pop_cnt + 1;
    if ((stk_push && stk_pop) || ((stk_push || stk_pop) && stk_reset)) viol_cnt <= viol_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; flush = 1'b0; force_err = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // One request through to ack, checking latency, strobes and results; returns in IDLE
  task automatic run_op(input bit use_b, input logic op, input logic [7:0] d,
                        input bit exp_err, input logic [7:0] exp_rd, input string tag);
    logic ack_x, err_x;
    if (use_b) begin req_b = 1'b1; op_b = op; wdata_b = d; end
    else       begin req_a = 1'b1; op_a = op; wdata_a = d; end
    step();
    ack_x = use_b ? ack_b : ack_a;
    err_x = use_b ? err_b : err_a;
    if (exp_err) begin
      chk({tag, "/rej_ack"}, ack_x, 1);
      chk({tag, "/rej_err"}, err_x, 1);
      chk({tag, "/rej_nostrobe"}, {stk_push, stk_pop}, 2'b00);
    end else begin
      chk({tag, "/early_ack"}, ack_x, 0);
      chk({tag, "/strobe"}, {stk_push, stk_pop}, (op == 1'b1) ? 2'b10 : 2'b01);
      if (op == 1'b1) chk({tag, "/wdata"}, stk_wdata, d);
      step();
      ack_x = use_b ? ack_b : ack_a;
      err_x = use_b ? err_b : err_a;
      chk({tag, "/ack"}, ack_x, 1);
      chk({tag, "/err"}, err_x, 0);
      if (op == 1'b0) chk({tag, "/rdata"}, rdata, exp_rd);
    end
    req_a = 1'b0; req_b = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int pc;
    op_a = 1'b0; op_b = 1'b0; wdata_a = 8'h00; wdata_b = 8'h00;
    do_reset();
    reset = 1'b1;
    step();
    chk("rst/stk_reset", stk_reset, 1);
    chk("rst/outs", {ack_a, ack_b, err_a, err_b, stk_push, stk_pop, mismatch, full}, 8'h00);
    chk("rst/empty", empty, 1);
    chk("rst/rdata", rdata, 8'h00);
    reset = 1'b0;
    step();
    chk("rst/stk_reset_rel", stk_reset, 0);

    // 1: A pushes two, pops two
    run_op(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, "t1_push11");
    run_op(1'b0, 1'b1, 8'h22, 1'b0, 8'h00, "t1_push22");
    chk("t1/not_empty", empty, 0);
    run_op(1'b0, 1'b0, 8'h00, 1'b0, 8'h22, "t1_pop22");
    run_op(1'b0, 1'b0, 8'h00, 1'b0, 8'h11, "t1_pop11");
    chk("t1/empty", empty, 1);

    // 2: both held, alternating grants, fill then overflow
    do_reset();
    req_a = 1'b1; op_a = 1'b1; wdata_a = 8'hA0;
    req_b = 1'b1; op_b = 1'b1; wdata_b = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t2/push_strobe%0d", i), stk_push, 1);
      step();
      chk($sformatf("t2/grant%0d", i), {ack_a, ack_b}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i % 2 == 0) wdata_a = 8'hA1; else wdata_b = 8'hB1;
      step();
    end
    chk("t2/full", full, 1);
    pc = push_cnt;
    step();
    chk("t2/ovf_ack_err", {ack_a, err_a, ack_b}, 3'b110);
    chk("t2/ovf_nopush", stk_push, 0);
    req_a = 1'b0; req_b = 1'b0;
    step();
    chk("t2/ovf_pushcnt", push_cnt, pc);
    chk("t2/still_full", full, 1);
    run_op(1'b0, 1'b0, 8'h00, 1'b0, 8'hB1, "t2_pop_top");

    // 3: pop on empty
    do_reset();
    pc = pop_cnt;
    run_op(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, "t3_underflow");
    chk("t3/popcnt", pop_cnt, pc);
    chk("t3/empty", empty, 1);
    run_op(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, "t3_push_after");
    run_op(1'b0, 1'b0, 8'h00, 1'b0, 8'h5A, "t3_pop_after");

    // 4: flush with three entries while B pop pending
    do_reset();
    run_op(1'b0, 1'b1, 8'h01, 1'b0, 8'h00, "t4_p1");
    run_op(1'b0, 1'b1, 8'h02, 1'b0, 8'h00, "t4_p2");
    run_op(1'b0, 1'b1, 8'h03, 1'b0, 8'h00, "t4_p3");
    chk("t4/pre_full_empty", {full, empty}, 2'b00);
    flush = 1'b1; req_b = 1'b1; op_b = 1'b0;
    step();
    chk("t4/stk_reset", stk_reset, 1);
    chk("t4/no_ack", {ack_a, ack_b, stk_pop}, 3'b000);
    chk("t4/empty", empty, 1);
    flush = 1'b0;
    step();
    chk("t4/b_pop_rej", {ack_b, err_b, stk_pop}, 3'b110);
    req_b = 1'b0;
    step();

    // 5: reset during ISSUE
    do_reset();
    req_a = 1'b1; op_a = 1'b1; wdata_a = 8'h55;
    step();
    chk("t5/issue_push", stk_push, 1);
    reset = 1'b1;
    step();
    chk("t5/no_ack", {ack_a, ack_b, stk_push}, 3'b000);
    chk("t5/stk_reset", stk_reset, 1);
    reset = 1'b0; req_a = 1'b0;
    step();
    chk("t5/empty", empty, 1);
    chk("t5/no_late_ack", ack_a, 0);
    run_op(1'b0, 1'b1, 8'h66, 1'b0, 8'h00, "t5_p66");
    run_op(1'b1, 1'b1, 8'h77, 1'b0, 8'h00, "t5_p77");
    run_op(1'b0, 1'b0, 8'h00, 1'b0, 8'h77, "t5_pop77");
    run_op(1'b1, 1'b0, 8'h00, 1'b0, 8'h66, "t5_pop66");
    run_op(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, "t5_pop_empty");

    // 6: stack error during an accepted op
    do_reset();
    req_a = 1'b1; op_a = 1'b1; wdata_a = 8'h99;
    step();
    force_err = 1'b1;
    step();
    chk("t6/ack", ack_a, 1);
    chk("t6/mm_not_yet", mismatch, 0);
    req_a = 1'b0;
    step();
    chk("t6/mismatch", mismatch, 1);
    force_err = 1'b0;
    step();
    step();
    chk("t6/sticky", mismatch, 1);
    do_reset();
    chk("t6/cleared", mismatch, 0);

    // 7: flush arriving mid-operation runs at the next IDLE
    run_op(1'b0, 1'b1, 8'h0F, 1'b0, 8'h00, "t7_push");
    req_a = 1'b1; op_a = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; req_a = 1'b0;
    chk("t7/pop_ack", ack_a, 1);
    chk("t7/pop_rdata", rdata, 8'h0F);
    step();
    chk("t7/no_reset_yet", stk_reset, 0);
    step();
    chk("t7/deferred_flush", stk_reset, 1);

    chk("global/strobe_rules", viol_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
